layer_addr_sequencer: RTL and testbench

LAYER_ADDR_SEQUENCER -- requirements
Module: layer_addr_sequencer

---
 rtl/layer_addr_sequencer_if.sv | 43 ++++
 rtl/layer_addr_sequencer.sv | 149 ++++++++++++++
 tb/tb_layer_addr_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer_addr_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : layer_addr_sequencer_if                                         |
// | Purpose  : Command and address bus for the layer address sequencer.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface layer_addr_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              cont;
    logic              stall;
    logic [CNT_W-1:0]  n_in;
    logic [CNT_W-1:0]  n_out;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] y_base;
    logic              busy;
    logic              done;
    logic              err;
    logic              addr_valid;
    logic              first_term;
    logic              last_term;
    logic              bias_term;
    logic              y_write;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] y_addr;

    modport master (
        output start, cont, stall, n_in, n_out, w_base, x_base, y_base,
        input  busy, done, err, addr_valid, first_term, last_term, bias_term,
               y_write, w_addr, x_addr, y_addr
    );

    modport slave (
        input  start, cont, stall, n_in, n_out, w_base, x_base, y_base,
        output busy, done, err, addr_valid, first_term, last_term, bias_term,
               y_write, w_addr, x_addr, y_addr
    );
endinterface
`default_nettype wire

// File: rtl/layer_addr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : layer_addr_sequencer                                            |
// | Purpose  : Walks weight/input/output addresses for one neural-net layer.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module layer_addr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 8,
    parameter int BIAS_EN = 0
) (
    input wire clk,
    input wire reset,
    layer_addr_sequencer_if.slave bus
);
    localparam int              c_TW   = CNT_W + 1;
    localparam logic [c_TW-1:0] c_BIAS = c_TW'(BIAS_EN);
    localparam logic [1:0]      c_IDLE = 2'd0;
    localparam logic [1:0]      c_RUN  = 2'd1;
    localparam logic [1:0]      c_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_n_in;
    logic [CNT_W-1:0]  r_n_out;
    logic [CNT_W-1:0]  r_j;
    logic [c_TW-1:0]   r_i;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_wb;
    logic [ADDR_W-1:0] r_xb;
    logic [ADDR_W-1:0] r_yb;
    logic [ADDR_W-1:0] r_cw;
    logic [ADDR_W-1:0] r_cx;
    logic [ADDR_W-1:0] r_cy;
    logic              r_err;

    logic [c_TW-1:0]   w_terms;
    logic [c_TW-1:0]   w_x_off;
    logic              w_run;
    logic              w_valid;
    logic              w_first;
    logic              w_last;
    logic              w_bias;
    logic              w_last_neuron;
    logic              w_accept;
    logic [ADDR_W-1:0] w_w_addr;
    logic [ADDR_W-1:0] w_x_addr;
    logic [ADDR_W-1:0] w_y_addr;

    always_comb begin
        // One extra bit keeps n_in = 2^CNT_W-1 plus a bias term representable
        w_terms       = {1'b0, r_n_in} + c_BIAS;
        w_run         = (r_state == c_RUN);
        w_valid       = w_run & ~bus.stall;
        w_first       = (r_i == '0);
        w_last        = (r_i == w_terms - c_TW'(1));
        w_bias        = (BIAS_EN != 0) && (r_i == {1'b0, r_n_in});
        w_last_neuron = (r_j == r_n_out - CNT_W'(1));
        w_x_off       = w_bias ? ({1'b0, r_n_in} - c_TW'(1)) : r_i;
        w_accept      = bus.start & (|bus.n_in) & (|bus.n_out);
        if (w_run) begin
            w_w_addr = r_wb + r_k;
            w_x_addr = r_xb + ADDR_W'(w_x_off);
            w_y_addr = r_yb + ADDR_W'(r_j);
        end else begin
            w_w_addr = r_wb;
            w_x_addr = r_xb;
            w_y_addr = r_yb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_n_in  <= '0;
            r_n_out <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_wb    <= '0;
            r_xb    <= '0;
            r_yb    <= '0;
            r_cw    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        if (w_accept) begin
                            r_state <= c_RUN;
                            r_n_in  <= bus.n_in;
                            r_n_out <= bus.n_out;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_k     <= '0;
                            if (bus.cont) begin
                                r_wb <= r_cw;
                                r_xb <= r_cx;
                                r_yb <= r_cy;
                            end else begin
                                r_wb <= bus.w_base;
                                r_xb <= bus.x_base;
                                r_yb <= bus.y_base;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    if (w_valid) begin
                        r_k <= r_k + ADDR_W'(1);
                        if (w_last) begin
                            r_i <= '0;
                            r_j <= r_j + CNT_W'(1);
                            // Continuation points one past the last address used
                            if (w_last_neuron) begin
                                r_state <= c_DONE;
                                r_cw    <= w_w_addr + ADDR_W'(1);
                                r_cx    <= r_xb + ADDR_W'(r_n_in);
                                r_cy    <= w_y_addr + ADDR_W'(1);
                            end
                        end else begin
                            r_i <= r_i + c_TW'(1);
                        end
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held, regardless of prior state
    assign bus.busy       = ~reset & w_run;
    assign bus.done       = ~reset & (r_state == c_DONE);
    assign bus.err        = ~reset & r_err;
    assign bus.addr_valid = ~reset & w_valid;
    assign bus.first_term = ~reset & w_valid & w_first;
    assign bus.last_term  = ~reset & w_valid & w_last;
    assign bus.bias_term  = ~reset & w_valid & w_bias;
    assign bus.y_write    = ~reset & w_valid & w_last;
    assign bus.w_addr     = reset ? '0 : w_w_addr;
    assign bus.x_addr     = reset ? '0 : w_x_addr;
    assign bus.y_addr     = reset ? '0 : w_y_addr;
endmodule
`default_nettype wire

// File: tb/tb_layer_addr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_layer_addr_sequencer                                         |
// | Purpose  : Scoreboard bench driving a no-bias and a bias sequencer in step.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_layer_addr_sequencer;
    typedef struct packed {
        logic [7:0] w;
        logic [7:0] x;
        logic [7:0] y;
        logic       first;
        logic       last;
        logic       bias;
        logic       yw;
    } item_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] n_in = '0;
    logic [7:0] n_out = '0;
    logic [7:0] w_base = '0;
    logic [7:0] x_base = '0;
    logic [7:0] y_base = '0;

    int    checks = 0;
    int    errors = 0;
    item_t q0[$];
    item_t q1[$];
    logic [7:0] cb_w[2], cb_x[2], cb_y[2];
    logic [7:0] lb_w[2], lb_x[2], lb_y[2];
    logic [7:0] pb_w[2], pb_x[2], pb_y[2];
    bit         pass_open[2];
    bit         prev_lastw[2];

    always #5 clk = ~clk;

    layer_addr_sequencer_if #(.ADDR_W(8), .CNT_W(8)) bus0 ();
    layer_addr_sequencer_if #(.ADDR_W(8), .CNT_W(8)) bus1 ();

    assign bus0.start = start;   assign bus1.start = start;
    assign bus0.cont = cont;     assign bus1.cont = cont;
    assign bus0.stall = stall;   assign bus1.stall = stall;
    assign bus0.n_in = n_in;     assign bus1.n_in = n_in;
    assign bus0.n_out = n_out;   assign bus1.n_out = n_out;
    assign bus0.w_base = w_base; assign bus1.w_base = w_base;
    assign bus0.x_base = x_base; assign bus1.x_base = x_base;
    assign bus0.y_base = y_base; assign bus1.y_base = y_base;

    layer_addr_sequencer #(.ADDR_W(8), .CNT_W(8), .BIAS_EN(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    layer_addr_sequencer #(.ADDR_W(8), .CNT_W(8), .BIAS_EN(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each pass is n_out neurons of (n_in + bias) terms, flat weight index
    task automatic model_pass(input int d, input int ni, input int no,
                              input logic [7:0] wb, input logic [7:0] xb,
                              input logic [7:0] yb, input bit c);
        int         t;
        logic [7:0] bw, bx, by;
        item_t      it;
        t  = ni + d;
        bw = c ? cb_w[d] : wb;
        bx = c ? cb_x[d] : xb;
        by = c ? cb_y[d] : yb;
        pb_w[d] = bw; pb_x[d] = bx; pb_y[d] = by;
        for (int j = 0; j < no; j++) begin
            for (int i = 0; i < t; i++) begin
                it.w     = 8'(int'(bw) + j * t + i);
                it.x     = 8'(int'(bx) + ((i < ni) ? i : ni - 1));
                it.y     = 8'(int'(by) + j);
                it.first = (i == 0);
                it.last  = (i == t - 1);
                it.bias  = (i == ni);
                it.yw    = (i == t - 1);
                if (d == 0) q0.push_back(it);
                else        q1.push_back(it);
            end
        end
        cb_w[d] = 8'(int'(bw) + no * t);
        cb_x[d] = 8'(int'(bx) + ni);
        cb_y[d] = 8'(int'(by) + no);
        pass_open[d] = 1'b1;
    endtask

    task automatic mon(input int d, input logic busy, input logic done, input logic err,
                       input logic valid, input logic first, input logic last,
                       input logic bias, input logic yw, input logic [7:0] w,
                       input logic [7:0] x, input logic [7:0] y);
        item_t obs, exp_it;
        int    qs;
        obs = {w, x, y, first, last, bias, yw};
        if (reset) begin
            chk($sformatf("reset_outputs%0d", d),
                {busy, done, err, valid, first, last, bias, yw, w, x, y}, 32'd0);
            prev_lastw[d] = 1'b0;
        end else begin
            if (valid) begin
                qs = (d == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_term%0d: got term %0h expected none", d, obs);
                end else begin
                    if (d == 0) exp_it = q0.pop_front();
                    else        exp_it = q1.pop_front();
                    chk($sformatf("term%0d", d), obs, exp_it);
                end
            end
            if (stall && busy) chk($sformatf("stall_hold%0d", d), valid, 1'b0);
            if (!busy) begin
                chk($sformatf("idle_flags%0d", d), {valid, first, last, bias, yw}, 5'd0);
                chk($sformatf("idle_addr%0d", d), {w, x, y}, {lb_w[d], lb_x[d], lb_y[d]});
            end
            qs = (d == 0) ? q0.size() : q1.size();
            if (done) begin
                chk($sformatf("done_timing%0d", d),
                    {pass_open[d], prev_lastw[d], qs == 0}, 3'b111);
                pass_open[d] = 1'b0;
            end
            prev_lastw[d] = valid & yw & (qs == 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.busy, bus0.done, bus0.err, bus0.addr_valid, bus0.first_term,
            bus0.last_term, bus0.bias_term, bus0.y_write, bus0.w_addr, bus0.x_addr, bus0.y_addr);
        mon(1, bus1.busy, bus1.done, bus1.err, bus1.addr_valid, bus1.first_term,
            bus1.last_term, bus1.bias_term, bus1.y_write, bus1.w_addr, bus1.x_addr, bus1.y_addr);
    end

    task automatic run_pass(input int ni, input int no, input logic [7:0] wb,
                            input logic [7:0] xb, input logic [7:0] yb,
                            input bit c, input int stall_pct);
        int cycles;
        model_pass(0, ni, no, wb, xb, yb, c);
        model_pass(1, ni, no, wb, xb, yb, c);
        @(posedge clk); #1;
        start = 1'b1; cont = c; stall = 1'b0;
        n_in = 8'(ni); n_out = 8'(no); w_base = wb; x_base = xb; y_base = yb;
        @(posedge clk); #1;
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            lb_w[d] = pb_w[d]; lb_x[d] = pb_x[d]; lb_y[d] = pb_y[d];
        end
        chk("first_valid", {bus0.addr_valid, bus1.addr_valid, bus0.busy, bus1.busy}, 4'hF);
        cycles = 0;
        while ((bus0.busy || bus0.done || bus1.busy || bus1.done) && cycles < 3000) begin
            stall = ($urandom_range(99) < stall_pct);
            // Starts while busy must be ignored by both units
            start = bus0.busy && bus1.busy && ($urandom_range(99) < 20);
            if (start) begin
                n_in = 8'($urandom_range(1, 255)); n_out = 8'($urandom_range(1, 255));
                cont = 1'($urandom_range(1));
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0; stall = 1'b0;
        chk("pass_timeout", cycles < 3000, 1'b1);
        chk("pass_end", {q0.size() == 0, q1.size() == 0, pass_open[0], pass_open[1]}, 4'b1100);
    endtask

    task automatic reject(input logic [7:0] ni, input logic [7:0] no);
        @(posedge clk); #1;
        start = 1'b1; cont = 1'b0; n_in = ni; n_out = no;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", {bus0.err, bus1.err, bus0.busy, bus1.busy}, 4'b1100);
        @(posedge clk); #1;
        chk("err_clear", {bus0.err, bus1.err, bus0.busy, bus1.busy}, 4'b0000);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cb_w[d] = '0; cb_x[d] = '0; cb_y[d] = '0;
            lb_w[d] = '0; lb_x[d] = '0; lb_y[d] = '0;
            pass_open[d] = 1'b0; prev_lastw[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_pass(3, 2, 8'h10, 8'h40, 8'h80, 1'b0, 0);
        run_pass(2, 1, 8'h00, 8'h00, 8'h00, 1'b1, 0);
        reject(8'd3, 8'd0);
        reject(8'd0, 8'd2);
        run_pass(4, 1, 8'hFE, 8'h20, 8'h30, 1'b0, 0);
        run_pass(3, 2, 8'h10, 8'h40, 8'h80, 1'b0, 40);
        run_pass(255, 1, 8'h05, 8'hF0, 8'h11, 1'b0, 10);
        for (int n = 0; n < 20; n++) begin
            run_pass($urandom_range(1, 6), $urandom_range(1, 4), 8'($urandom), 8'($urandom),
                     8'($urandom), 1'($urandom_range(1)), 30);
        end

        // Abort mid-pass: reset lands in the third valid cycle
        model_pass(0, 4, 3, 8'h50, 8'h60, 8'h70, 1'b0);
        model_pass(1, 4, 3, 8'h50, 8'h60, 8'h70, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; cont = 1'b0; stall = 1'b0;
        n_in = 8'd4; n_out = 8'd3; w_base = 8'h50; x_base = 8'h60; y_base = 8'h70;
        @(posedge clk); #1;
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            lb_w[d] = pb_w[d]; lb_x[d] = pb_x[d]; lb_y[d] = pb_y[d];
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        q0.delete(); q1.delete();
        for (int d = 0; d < 2; d++) begin
            cb_w[d] = '0; cb_x[d] = '0; cb_y[d] = '0;
            lb_w[d] = '0; lb_x[d] = '0; lb_y[d] = '0;
            pass_open[d] = 1'b0;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_reset0", {bus0.busy, bus0.done, bus0.addr_valid, bus0.w_addr, bus0.x_addr, bus0.y_addr}, 32'd0);
        chk("post_reset1", {bus1.busy, bus1.done, bus1.addr_valid, bus1.w_addr, bus1.x_addr, bus1.y_addr}, 32'd0);
        run_pass(2, 2, 8'hAA, 8'hBB, 8'hCC, 1'b1, 20);
        run_pass(3, 1, 8'h01, 8'h02, 8'h03, 1'b1, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
